mem_access_unit: RTL

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit_pkg.sv | 29 ++
 rtl/mem_access_unit_if.sv | 28 ++
 rtl/mem_access_unit_byte_lane_unit.sv | 50 +++++
 rtl/mem_access_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store path: access sizes, FSM states and
// the alignment rule used to reject a request before it touches memory.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WRITE   = 2'd2,
        ST_RESP    = 2'd3
    } mau_state_e;

    // Reserved size counts as an error alongside misalignment.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = lane[0];
            SZ_WORD: err = (lane != 2'b00);
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake and word-memory bus of the memory access unit.
interface mem_access_unit_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_wr;
    logic [31:0]       mem_rdata;

    modport slave (
        input  req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wr
    );

    modport master (
        output req_valid, req_write, req_size, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_wr
    );
endinterface

// File: rtl/mem_access_unit_byte_lane_unit.sv
// Little-endian lane select with sign extension for loads, and lane merge
// into the old word for sub-word stores.
module byte_lane_unit
    import mem_access_unit_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic [31:0] rword_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rword_i[7:0];
        case (lane_i)
            2'd1:    byte_sel = rword_i[15:8];
            2'd2:    byte_sel = rword_i[23:16];
            2'd3:    byte_sel = rword_i[31:24];
            default: byte_sel = rword_i[7:0];
        endcase
        half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

        load_o  = rword_i;
        merge_o = rword_i;
        case (size_i)
            SZ_BYTE: begin
                load_o = {{24{byte_sel[7]}}, byte_sel};
                case (lane_i)
                    2'd1:    merge_o[15:8]  = wdata_i[7:0];
                    2'd2:    merge_o[23:16] = wdata_i[7:0];
                    2'd3:    merge_o[31:24] = wdata_i[7:0];
                    default: merge_o[7:0]   = wdata_i[7:0];
                endcase
            end
            SZ_HALF: begin
                load_o = {{16{half_sel[15]}}, half_sel};
                if (lane_i[1]) merge_o[31:16] = wdata_i[15:0];
                else           merge_o[15:0]  = wdata_i[15:0];
            end
            SZ_WORD: begin
                load_o  = rword_i;
                merge_o = wdata_i;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: aligns byte/half/word accesses onto a word memory
// with fixed read latency, doing read-modify-write for sub-word stores.
//   state   | meaning
//   IDLE    | ready for a request
//   RD_WAIT | word address held, waiting MEM_LAT cycles for read data
//   WRITE   | one-cycle word write strobe
//   RESP    | one-cycle completion pulse
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int ADDR_W  = 32
) (
    input  logic            clk,
    input  logic            reset,
    mem_access_unit_if.slave bus
);
    if (MEM_LAT < 1 || MEM_LAT > 7) begin : g_lat_check
        $error("mem_access_unit: MEM_LAT must be within 1..7");
    end

    localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

    mau_state_e        state_q;
    logic [2:0]        cnt_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              write_q;
    logic [31:0]       wdata_q;
    logic              req_ready_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;
    logic              mem_wr_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;

    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic        req_err_d;

    assign req_err_d = access_error(bus.req_size, bus.req_addr[1:0]);

    byte_lane_unit u_lane (
        .size_i  (size_q),
        .lane_i  (lane_q),
        .rword_i (bus.mem_rdata),
        .wdata_i (wdata_q),
        .load_o  (load_d),
        .merge_o (merge_d)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            lane_q       <= 2'd0;
            size_q       <= SZ_BYTE;
            write_q      <= 1'b0;
            wdata_q      <= 32'd0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (bus.req_valid && req_ready_q) begin
                        req_ready_q <= 1'b0;
                        lane_q      <= bus.req_addr[1:0];
                        size_q      <= bus.req_size;
                        write_q     <= bus.req_write;
                        wdata_q     <= bus.req_wdata;
                        if (req_err_d) begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= 32'd0;
                        end else begin
                            mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
                            if (bus.req_write && bus.req_size == SZ_WORD) begin
                                state_q     <= ST_WRITE;
                                mem_wr_q    <= 1'b1;
                                mem_wdata_q <= bus.req_wdata;
                            end else begin
                                state_q <= ST_RD_WAIT;
                                cnt_q   <= CNT_INIT;
                            end
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (cnt_q == 3'd0) begin
                        if (write_q) begin
                            state_q     <= ST_WRITE;
                            mem_wr_q    <= 1'b1;
                            mem_wdata_q <= merge_d;
                        end else begin
                            state_q      <= ST_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= load_d;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                ST_WRITE: begin
                    state_q      <= ST_RESP;
                    mem_wr_q     <= 1'b0;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                ST_RESP: begin
                    state_q      <= ST_IDLE;
                    req_ready_q  <= 1'b1;
                    resp_valid_q <= 1'b0;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 32'd0;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.mem_wr     = mem_wr_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule
